// File: rtl/pipeline_param_core_if.sv
// Instruction, stall, debug and retirement signals of pipeline_param_core.
// The core connects through the slave modport; the driving side uses master.
interface pipeline_param_core_if #(
  parameter int DW    = 8,
  parameter int NREG  = 4,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 3 + 3 * RW;

  logic [IW-1:0]     inst;
  logic              inst_valid;
  logic              inst_ready;
  logic              stallex;
  logic              stallwb;
  logic [RW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic              retire_valid;
  logic [RW-1:0]     retire_rd;
  logic              retire_wen;
  logic [DW-1:0]     retire_val;
  logic [CNT_W-1:0]  retire_cnt;
  logic [2*NREG-1:0] scb_flat;

  modport master (
    output inst, inst_valid, stallex, stallwb, dbg_addr,
    input  inst_ready, dbg_data, retire_valid, retire_rd, retire_wen,
           retire_val, retire_cnt, scb_flat
  );

  modport slave (
    input  inst, inst_valid, stallex, stallwb, dbg_addr,
    output inst_ready, dbg_data, retire_valid, retire_rd, retire_wen,
           retire_val, retire_cnt, scb_flat
  );
endinterface

// File: rtl/pipeline_param_core.sv
// Three-stage (ID -> EX -> WB) register-file core with a per-register
// scoreboard. Operands are resolved when an instruction is accepted in ID,
// either by forwarding (FWD=1) or by interlocking until no write is pending
// (FWD=0). SET carries its immediate in the rs1/rs2 fields.
module pipeline_param_core #(
  parameter int DW    = 8,
  parameter int NREG  = 4,
  parameter int FWD   = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_param_core_if.slave  bus
);
  localparam int RW = $clog2(NREG);
  localparam int IW = 3 + 3 * RW;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;

  logic [2:0]       id_op;
  logic [RW-1:0]    id_rs1, id_rs2, id_rd;
  logic             id_wen, id_uses_src;
  logic [DW-1:0]    id_opa, id_opb;
  logic             hazard;
  logic             ex_ready, ex_go, wb_go, id_go;

  logic             id_ex_valid_q;
  logic [2:0]       id_ex_op_q;
  logic [DW-1:0]    id_ex_a_q, id_ex_b_q;
  logic [RW-1:0]    id_ex_rd_q;
  logic             id_ex_wen_q;
  logic [DW-1:0]    ex_res;

  logic             ex_wb_valid_q;
  logic [RW-1:0]    ex_wb_rd_q;
  logic             ex_wb_wen_q;
  logic [DW-1:0]    ex_wb_val_q;

  logic [DW-1:0]    rf_q [NREG];
  logic [NREG-1:0]  scb_ex_q, scb_ex_d;
  logic [NREG-1:0]  scb_wb_q, scb_wb_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign id_op  = bus.inst[IW-1 -: 3];
  assign id_rs1 = bus.inst[3*RW-1 -: RW];
  assign id_rs2 = bus.inst[2*RW-1 -: RW];
  assign id_rd  = bus.inst[RW-1:0];

  // Decode write enable and whether register sources are actually read.
  always_comb begin
    id_wen      = id_op inside {OP_ADD, OP_SET, OP_NAND, OP_SUB, OP_XOR};
    id_uses_src = id_op inside {OP_ADD, OP_NAND, OP_SUB, OP_XOR};
  end

  // Operand resolution: the EX-stage writer is newer than the WB-stage one,
  // so it is applied last and wins. SET replaces operand A with its immediate.
  always_comb begin
    id_opa = rf_q[id_rs1];
    id_opb = rf_q[id_rs2];
    if (scb_wb_q[id_rs1]) id_opa = ex_wb_val_q;
    if (scb_wb_q[id_rs2]) id_opb = ex_wb_val_q;
    if (scb_ex_q[id_rs1]) id_opa = ex_res;
    if (scb_ex_q[id_rs2]) id_opb = ex_res;
    if (id_op == OP_SET)  id_opa = DW'({id_rs1, id_rs2});
  end

  // Interlock only exists in the non-forwarding build.
  always_comb begin
    hazard = 1'b0;
    if (FWD == 0 && id_uses_src &&
        (scb_ex_q[id_rs1] || scb_wb_q[id_rs1] ||
         scb_ex_q[id_rs2] || scb_wb_q[id_rs2]))
      hazard = 1'b1;
  end

  assign ex_ready       = !bus.stallex && (!ex_wb_valid_q || !bus.stallwb);
  assign wb_go          = ex_wb_valid_q && !bus.stallwb;
  assign ex_go          = id_ex_valid_q && ex_ready;
  assign bus.inst_ready = !rst && (!id_ex_valid_q || ex_ready) && !hazard;
  assign id_go          = bus.inst_valid && bus.inst_ready;

  // EX-stage ALU.
  always_comb begin
    ex_res = '0;
    case (id_ex_op_q)
      OP_ADD:  ex_res = id_ex_a_q + id_ex_b_q;
      OP_SET:  ex_res = id_ex_a_q;
      OP_NAND: ex_res = ~(id_ex_a_q & id_ex_b_q);
      OP_SUB:  ex_res = id_ex_a_q - id_ex_b_q;
      OP_XOR:  ex_res = id_ex_a_q ^ id_ex_b_q;
      default: ex_res = '0;
    endcase
  end

  // Scoreboard next state: bit1 tracks the EX-stage writer, bit0 the WB one.
  always_comb begin
    scb_ex_d = scb_ex_q;
    scb_wb_d = scb_wb_q;
    for (int i = 0; i < NREG; i++) begin
      if (id_go)      scb_ex_d[i] = id_wen && (id_rd == RW'(i));
      else if (ex_go) scb_ex_d[i] = 1'b0;
      if (ex_go)      scb_wb_d[i] = id_ex_wen_q && (id_ex_rd_q == RW'(i));
      else if (wb_go) scb_wb_d[i] = 1'b0;
    end
  end

  assign retire_cnt_d = wb_go ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;

  // ID/EX stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid_q <= 1'b0;
      id_ex_op_q    <= '0;
      id_ex_a_q     <= '0;
      id_ex_b_q     <= '0;
      id_ex_rd_q    <= '0;
      id_ex_wen_q   <= 1'b0;
    end else if (id_go) begin
      id_ex_valid_q <= 1'b1;
      id_ex_op_q    <= id_op;
      id_ex_a_q     <= id_opa;
      id_ex_b_q     <= id_opb;
      id_ex_rd_q    <= id_rd;
      id_ex_wen_q   <= id_wen;
    end else if (ex_go) begin
      id_ex_valid_q <= 1'b0;
    end
  end

  // EX/WB stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wb_valid_q <= 1'b0;
      ex_wb_rd_q    <= '0;
      ex_wb_wen_q   <= 1'b0;
      ex_wb_val_q   <= '0;
    end else if (ex_go) begin
      ex_wb_valid_q <= 1'b1;
      ex_wb_rd_q    <= id_ex_rd_q;
      ex_wb_wen_q   <= id_ex_wen_q;
      ex_wb_val_q   <= ex_res;
    end else if (wb_go) begin
      ex_wb_valid_q <= 1'b0;
    end
  end

  // Register file write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_go && ex_wb_wen_q) begin
      rf_q[ex_wb_rd_q] <= ex_wb_val_q;
    end
  end

  // Scoreboard and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scb_ex_q     <= '0;
      scb_wb_q     <= '0;
      retire_cnt_q <= '0;
    end else begin
      scb_ex_q     <= scb_ex_d;
      scb_wb_q     <= scb_wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Flatten scoreboard as {bit1, bit0} per register.
  always_comb begin
    bus.scb_flat = '0;
    for (int i = 0; i < NREG; i++) begin
      bus.scb_flat[2*i+1] = scb_ex_q[i];
      bus.scb_flat[2*i]   = scb_wb_q[i];
    end
  end

  assign bus.dbg_data     = rf_q[bus.dbg_addr];
  assign bus.retire_valid = wb_go;
  assign bus.retire_rd    = ex_wb_rd_q;
  assign bus.retire_wen   = ex_wb_wen_q;
  assign bus.retire_val   = ex_wb_val_q;
  assign bus.retire_cnt   = retire_cnt_q;
endmodule

// File: tb/tb_pipeline_param_core.sv
// Bench for pipeline_param_core: a forwarding instance (4-bit retire counter)
// and an interlocking instance, each followed by an architectural model that
// executes accepted instructions in program order and predicts retirements.
module tb_pipeline_param_core;
  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SET = 3'd2, NAND = 3'd3,
                         SUB = 3'd4, XOR = 3'd5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_param_core_if #(.DW(8), .NREG(4), .CNT_W(4))  if1 ();
  pipeline_param_core_if #(.DW(8), .NREG(4), .CNT_W(16)) if0 ();

  pipeline_param_core #(.DW(8), .NREG(4), .FWD(1), .CNT_W(4))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipeline_param_core #(.DW(8), .NREG(4), .FWD(0), .CNT_W(16))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  typedef struct packed {
    logic [1:0] rd;
    logic       wen;
    logic [7:0] val;
  } ret_t;

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rs1,
                                    input logic [1:0] rs2, input logic [1:0] rd);
    return {op, rs1, rs2, rd};
  endfunction

  // Architectural meaning of one instruction given its source values.
  function automatic ret_t exec(input logic [8:0] ins, input logic [7:0] a,
                                input logic [7:0] b);
    ret_t r;
    r.rd  = ins[1:0];
    r.wen = (ins[8:6] >= 3'd1) && (ins[8:6] <= 3'd5);
    case (ins[8:6])
      ADD:     r.val = a + b;
      SET:     r.val = {4'b0000, ins[5:2]};
      NAND:    r.val = ~(a & b);
      SUB:     r.val = a - b;
      XOR:     r.val = a ^ b;
      default: r.val = 8'h00;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  m1_rf [4];
  ret_t        m1_q [$];
  int unsigned m1_cnt;
  logic [7:0]  m0_rf [4];
  ret_t        m0_q [$];
  int unsigned m0_cnt;

  always @(negedge clk) begin : mon1
    ret_t e, r;
    if (rst) begin
      foreach (m1_rf[i]) m1_rf[i] = 8'h00;
      m1_q.delete();
      m1_cnt = 0;
    end else begin
      chk("cnt1", 32'(if1.retire_cnt), m1_cnt % 16);
      if (if1.retire_valid) begin
        m1_cnt++;
        if (m1_q.size() == 0) chk("ret1_unexpected", 32'(if1.retire_valid), 0);
        else begin
          e = m1_q.pop_front();
          chk("ret1_rd", 32'(if1.retire_rd), 32'(e.rd));
          chk("ret1_wen", 32'(if1.retire_wen), 32'(e.wen));
          if (e.wen) chk("ret1_val", 32'(if1.retire_val), 32'(e.val));
        end
      end
      if (if1.inst_valid && if1.inst_ready) begin
        r = exec(if1.inst, m1_rf[if1.inst[5:4]], m1_rf[if1.inst[3:2]]);
        if (r.wen) m1_rf[r.rd] = r.val;
        m1_q.push_back(r);
      end
    end
  end

  always @(negedge clk) begin : mon0
    ret_t e, r;
    if (rst) begin
      foreach (m0_rf[i]) m0_rf[i] = 8'h00;
      m0_q.delete();
      m0_cnt = 0;
    end else begin
      chk("cnt0", 32'(if0.retire_cnt), m0_cnt % 65536);
      if (if0.retire_valid) begin
        m0_cnt++;
        if (m0_q.size() == 0) chk("ret0_unexpected", 32'(if0.retire_valid), 0);
        else begin
          e = m0_q.pop_front();
          chk("ret0_rd", 32'(if0.retire_rd), 32'(e.rd));
          chk("ret0_wen", 32'(if0.retire_wen), 32'(e.wen));
          if (e.wen) chk("ret0_val", 32'(if0.retire_val), 32'(e.val));
        end
      end
      if (if0.inst_valid && if0.inst_ready) begin
        r = exec(if0.inst, m0_rf[if0.inst[5:4]], m0_rf[if0.inst[3:2]]);
        if (r.wen) m0_rf[r.rd] = r.val;
        m0_q.push_back(r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if1.inst = '0; if1.inst_valid = 1'b0; if1.stallex = 1'b0; if1.stallwb = 1'b0; if1.dbg_addr = '0;
    if0.inst = '0; if0.inst_valid = 1'b0; if0.stallex = 1'b0; if0.stallwb = 1'b0; if0.dbg_addr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Forwarding: SET r1=5, SET r2=3, ADD r3 back-to-back; first accept right after reset.
    do_reset();
    if1.inst = mk(SET, 2'd1, 2'd1, 2'd1); if1.inst_valid = 1'b1;
    mid(); chk("fw_rdy0", 32'(if1.inst_ready), 1); chk("fw_scb0", 32'(if1.scb_flat), 32'h00);
    tick(); if1.inst = mk(SET, 2'd0, 2'd3, 2'd2);
    mid(); chk("fw_rdy1", 32'(if1.inst_ready), 1); chk("fw_scb1", 32'(if1.scb_flat), 32'h08);
    tick(); if1.inst = mk(ADD, 2'd1, 2'd2, 2'd3);
    mid(); chk("fw_rdy2", 32'(if1.inst_ready), 1);
    chk("fw_rv1", 32'(if1.retire_valid), 1); chk("fw_rd1", 32'(if1.retire_rd), 1);
    chk("fw_val1", 32'(if1.retire_val), 32'h05);
    tick(); if1.inst_valid = 1'b0;
    mid(); chk("fw_rv2", 32'(if1.retire_valid), 1); chk("fw_val2", 32'(if1.retire_val), 32'h03);
    tick();
    mid(); chk("fw_rv3", 32'(if1.retire_valid), 1); chk("fw_rd3", 32'(if1.retire_rd), 3);
    chk("fw_val3", 32'(if1.retire_val), 32'h08);
    tick(); if1.dbg_addr = 2'd3;
    mid(); chk("fw_r3", 32'(if1.dbg_data), 32'h08);

    // Interlock: same program, ADD waits exactly two cycles.
    do_reset();
    if0.inst = mk(SET, 2'd1, 2'd1, 2'd1); if0.inst_valid = 1'b1;
    mid(); chk("il_rdy0", 32'(if0.inst_ready), 1);
    tick(); if0.inst = mk(SET, 2'd0, 2'd3, 2'd2);
    mid(); chk("il_rdy1", 32'(if0.inst_ready), 1); chk("il_scb1", 32'(if0.scb_flat), 32'h08);
    tick(); if0.inst = mk(ADD, 2'd1, 2'd2, 2'd3);
    mid(); chk("il_rdy2", 32'(if0.inst_ready), 0); chk("il_scb2", 32'(if0.scb_flat), 32'h24);
    tick();
    mid(); chk("il_rdy3", 32'(if0.inst_ready), 0); chk("il_scb3", 32'(if0.scb_flat), 32'h10);
    tick();
    mid(); chk("il_rdy4", 32'(if0.inst_ready), 1); chk("il_scb4", 32'(if0.scb_flat), 32'h00);
    tick(); if0.inst_valid = 1'b0;
    mid(); chk("il_scb5", 32'(if0.scb_flat), 32'h80);
    tick();
    mid(); chk("il_scb6", 32'(if0.scb_flat), 32'h40); chk("il_val", 32'(if0.retire_val), 32'h08);
    tick(); if0.dbg_addr = 2'd3;
    mid(); chk("il_scb7", 32'(if0.scb_flat), 32'h00); chk("il_r3", 32'(if0.dbg_data), 32'h08);

    // SUB underflow then NAND of the result, all forwarded.
    do_reset();
    if1.inst_valid = 1'b1;
    if1.inst = mk(SET, 2'd0, 2'd2, 2'd0);  mid(); chk("sn_rdy0", 32'(if1.inst_ready), 1); tick();
    if1.inst = mk(SET, 2'd0, 2'd3, 2'd1);  mid(); chk("sn_rdy1", 32'(if1.inst_ready), 1); tick();
    if1.inst = mk(SUB, 2'd0, 2'd1, 2'd2);  mid(); chk("sn_rdy2", 32'(if1.inst_ready), 1); tick();
    if1.inst = mk(NAND, 2'd2, 2'd2, 2'd3); mid(); chk("sn_rdy3", 32'(if1.inst_ready), 1); tick();
    if1.inst_valid = 1'b0;
    repeat (3) tick();
    if1.dbg_addr = 2'd2; mid(); chk("sn_r2", 32'(if1.dbg_data), 32'hFF);
    if1.dbg_addr = 2'd3; #1;   chk("sn_r3", 32'(if1.dbg_data), 32'h00);

    // Full pipeline held by stallwb for three cycles.
    do_reset();
    if1.stallwb = 1'b1; if1.inst_valid = 1'b1;
    if1.inst = mk(SET, 2'd0, 2'd1, 2'd1); tick();
    if1.inst = mk(SET, 2'd0, 2'd2, 2'd2); tick();
    if1.inst = mk(XOR, 2'd1, 2'd2, 2'd3);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("st_rdy", 32'(if1.inst_ready), 0);
      chk("st_rv", 32'(if1.retire_valid), 0);
      chk("st_scb", 32'(if1.scb_flat), 32'h24);
      tick();
    end
    if1.stallwb = 1'b0;
    mid(); chk("st_rel_rv", 32'(if1.retire_valid), 1); chk("st_rel_rd", 32'(if1.retire_rd), 1);
    chk("st_rel_rdy", 32'(if1.inst_ready), 1);
    tick(); if1.inst_valid = 1'b0;
    repeat (3) tick();
    if1.dbg_addr = 2'd3; mid(); chk("st_r3", 32'(if1.dbg_data), 32'h03);

    // Retire counter wrap at 4 bits.
    do_reset();
    if1.inst = mk(NOP, 2'd0, 2'd0, 2'd0); if1.inst_valid = 1'b1;
    repeat (15) tick();
    if1.inst_valid = 1'b0;
    repeat (3) tick();
    mid(); chk("wr_15", 32'(if1.retire_cnt), 15);
    tick(); if1.inst_valid = 1'b1; tick(); if1.inst_valid = 1'b0; repeat (3) tick();
    mid(); chk("wr_0", 32'(if1.retire_cnt), 0);
    tick(); if1.inst_valid = 1'b1; tick(); if1.inst_valid = 1'b0; repeat (3) tick();
    mid(); chk("wr_1", 32'(if1.retire_cnt), 1);

    // Random traffic on both cores, with an asynchronous reset in the middle.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [8:0] ri;
      logic       rv, rse, rsw;
      ri  = 9'($urandom);
      rv  = ($urandom_range(0, 3) != 0);
      rse = ($urandom_range(0, 4) == 0);
      rsw = ($urandom_range(0, 4) == 0);
      if1.inst = ri; if1.inst_valid = rv; if1.stallex = rse; if1.stallwb = rsw;
      if0.inst = ri; if0.inst_valid = rv; if0.stallex = rse; if0.stallwb = rsw;
      if1.dbg_addr = 2'($urandom); if0.dbg_addr = if1.dbg_addr;
      tick();
      if (c == 200) begin
        #2 rst = 1'b1;
        #1;
        chk("rs_rdy1", 32'(if1.inst_ready), 0);   chk("rs_rdy0", 32'(if0.inst_ready), 0);
        chk("rs_rv1", 32'(if1.retire_valid), 0);  chk("rs_rv0", 32'(if0.retire_valid), 0);
        chk("rs_scb1", 32'(if1.scb_flat), 0);     chk("rs_scb0", 32'(if0.scb_flat), 0);
        chk("rs_dbg1", 32'(if1.dbg_data), 0);     chk("rs_dbg0", 32'(if0.dbg_data), 0);
        chk("rs_cnt1", 32'(if1.retire_cnt), 0);   chk("rs_cnt0", 32'(if0.retire_cnt), 0);
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          mid();
          chk("rs_quiet1", 32'(if1.retire_valid), 0);
          chk("rs_quiet0", 32'(if0.retire_valid), 0);
          tick();
        end
      end
    end

    idle_inputs();
    repeat (8) tick();
    mid();
    chk("drain1", m1_q.size(), 0);
    chk("drain0", m0_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      if1.dbg_addr = 2'(i); if0.dbg_addr = 2'(i);
      #1;
      chk("rf1", 32'(if1.dbg_data), 32'(m1_rf[i]));
      chk("rf0", 32'(if0.dbg_data), 32'(m0_rf[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_param_core.md
PIPELINE_PARAM_CORE -- requirements
Module: pipeline_param_core

Interface
REQ-001 SHALL have parameter DW, default 8, datapath/register width (>=4).
REQ-002 SHALL have parameter NREG, default 4, register count (power of two, >=2); RW = log2(NREG).
REQ-003 SHALL have parameter FWD, default 1, 1 = forward from EX/WB, 0 = interlock on any pending source write.
REQ-004 SHALL have parameter CNT_W, default 16, retire-counter width.
REQ-005 SHALL define IW = 3+3*RW; instruction = {op[2:0], rs1, rs2, rd}, rd in LSBs.
REQ-006 clk  input  1  clock; one clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 inst  input  IW  instruction.
REQ-009 inst_valid  input  1  instruction valid.
REQ-010 inst_ready  output  1  core accepts inst this cycle.
REQ-011 stallex  input  1  holds EX stage.
REQ-012 stallwb  input  1  holds WB stage.
REQ-013 dbg_addr  input  RW  debug read index; dbg_data  output  DW  = RF[dbg_addr], combinational.
REQ-014 retire_valid  output  1  instruction leaving WB this cycle.
REQ-015 retire_rd  output  RW, retire_wen  output  1, retire_val  output  DW  retiring destination, write flag, result.
REQ-016 retire_cnt  output  CNT_W  count of retired instructions.
REQ-017 scb_flat  output  2*NREG  scoreboard, entry i at bits [2i+1:2i].

Function
REQ-018 Ops: 000 NOP, 001 ADD, 010 SET, 011 NAND, 100 SUB, 101 XOR; 110/111 SHALL behave as NOP (no write).
REQ-019 ADD/SUB SHALL be modulo 2^DW (SUB = rs1-rs2); NAND/XOR bitwise; SET result = {rs1,rs2} zero-extended to DW.
REQ-020 Pipeline SHALL be ID -> EX -> WB with regs id_ex_valid, ex_wb_valid; one instruction per stage max.
REQ-021 ex_ready = !stallex && (!ex_wb_valid || !stallwb); wb_go = ex_wb_valid && !stallwb; ex_go = id_ex_valid && ex_ready.
REQ-022 inst_ready = !rst && (!id_ex_valid || ex_ready) && !hazard; id_go = inst_valid && inst_ready.
REQ-023 hazard SHALL be 0 when FWD=1; when FWD=0, 1 iff op in {ADD,NAND,SUB,XOR} and scoreboard[rs1] or scoreboard[rs2] nonzero.
REQ-024 Stage regs SHALL hold when their stage does not advance; id_ex_valid clears on ex_go without id_go; ex_wb_valid clears on wb_go without ex_go.
REQ-025 Scoreboard bit1 of entry i SHALL mean "writer of i in EX"; next = id_go ? (wen && rd==i) : ex_go ? 0 : hold.
REQ-026 Scoreboard bit0 of entry i SHALL mean "writer of i in WB"; next = ex_go ? (id_ex wen && id_ex_rd==i) : wb_go ? 0 : hold.
REQ-027 Operand select (FWD=1): bit1 set -> EX ALU result; else bit0 set -> ex_wb value; else RF; EX SHALL take priority.
REQ-028 RF write SHALL occur at the edge where wb_go && ex_wb_wen; same-cycle ID read of that reg SHALL use forwarded value.
REQ-029 Latency: instruction accepted at edge N SHALL assert retire_valid in cycle after edge N+1 and update RF at edge N+2, absent stalls.
REQ-030 retire_valid = wb_go; retire_rd/wen/val = ex_wb contents; retirement SHALL be in program order.
REQ-031 retire_cnt SHALL increment on each wb_go (NOPs included), wrap 2^CNT_W-1 -> 0.
REQ-032 Simultaneous id_go, ex_go, wb_go SHALL all take effect in one edge with no bubble.

Reset
REQ-033 rst SHALL asynchronously clear RF, scoreboard, id_ex_valid, ex_wb_valid, ex_wb fields, retire_cnt to 0.
REQ-034 During rst: inst_ready=0, retire_valid=0, dbg_data=0, scb_flat=0; in-flight instructions discarded.
REQ-035 First accept SHALL be possible in first cycle after rst deasserts.

Verification
REQ-036 DW=8,NREG=4,FWD=1: SET r1=5, SET r2=3, ADD r3=r1+r2 back-to-back -> retires 1 cycle apart, r3=0x08, inst_ready stays 1.
REQ-037 FWD=0, same sequence -> inst_ready low exactly 2 cycles while ADD presented; r3=0x08; scb_flat transitions per REQ-025/026.
REQ-038 Pipeline full, stallwb=1 for 3 cycles -> inst_ready=0, retire_valid=0, state holds; release -> retires resume in order.
REQ-039 SET r0=2, SET r1=3, SUB r2=r0-r1, NAND r3=r2,r2 -> r2=0xFF, r3=0x00.
REQ-040 rst asserted mid-stream between clock edges -> all outputs zero immediately, no instruction retires afterward.
REQ-041 CNT_W=4: 17 retirements -> retire_cnt passes 15 -> 0 -> 1.
